alu_issue_decoder: RTL and testbench

//  Producer side of the ALU op interface: decodes 32-bit RV32 instruction words into
//  alu_op_e plus operands and issues them to alu via valid/ready. Sits between register

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_skid_buf.sv | 56 +++++
 rtl/alu_issue_decoder.sv | 113 +++++++++++
 tb/tb_alu_issue_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU op encoding, RV32 decode field constants and the default issue packet.
// Packet fields here use the 32-bit default width; width-generic users define their own.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD_OP = 2'd0,
        SUB_OP = 2'd1,
        AND_OP = 2'd2,
        OR_OP  = 2'd3
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    localparam int ALU_DATA_W = 32;

    typedef struct packed {
        alu_op_e                 op;
        logic [ALU_DATA_W-1:0]   elemA;
        logic [ALU_DATA_W-1:0]   elemB;
        logic [4:0]              rd;
    } issue_pkt_t;

    // Maps the three legal funct3 values shared by OP and OP_IMM; SUB is handled by the caller.
    function automatic logic f3_to_op(input logic [2:0] f3, output alu_op_e op);
        op = ADD_OP;
        case (f3)
            F3_ADD_SUB: begin op = ADD_OP; return 1'b1; end
            F3_AND:     begin op = AND_OP; return 1'b1; end
            F3_OR:      begin op = OR_OP;  return 1'b1; end
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer: slot0 drives the outputs, slot1 catches one
// extra accept while slot0 is stalled. Ready depends only on registered state.
module alu_skid_buf
    import alu_pkg::*;
#(
    parameter type T = issue_pkt_t
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_valid,
    output logic o_ready,
    input  T     i_data,
    output logic o_valid,
    input  logic i_ready,
    output T     o_data
);

    logic s0_full;
    logic s1_full;
    T     s0_data;
    T     s1_data;
    logic accept;

    assign accept  = i_valid && !s1_full;
    assign o_ready = !s1_full;
    assign o_valid = s0_full;
    assign o_data  = s0_data;

    // slot1 can only be occupied while slot0 is, so the empty-slot0 branch ignores it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s0_full <= 1'b0;
            s1_full <= 1'b0;
            s0_data <= '0;
            s1_data <= '0;
        end else if (!s0_full) begin
            if (accept) begin
                s0_data <= i_data;
                s0_full <= 1'b1;
            end
        end else if (i_ready) begin
            if (s1_full) begin
                s0_data <= s1_data;
                s1_full <= 1'b0;
            end else if (accept) begin
                s0_data <= i_data;
            end else begin
                s0_full <= 1'b0;
            end
        end else if (accept) begin
            s1_data <= i_data;
            s1_full <= 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue_decoder.sv
// Decodes RV32 OP/OP_IMM words into ALU issue packets behind a two-entry skid buffer.
// Illegal encodings are consumed, pulsed on o_illegal and counted, never issued.
module alu_issue_decoder
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [31:0]           i_instr,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output alu_op_e               o_op,
    output logic [DATA_WIDTH-1:0] o_elemA,
    output logic [DATA_WIDTH-1:0] o_elemB,
    output logic [4:0]            o_rd,
    output logic                  o_illegal,
    output logic [CNT_W-1:0]      o_illegal_cnt
);

    typedef struct packed {
        alu_op_e                 op;
        logic [DATA_WIDTH-1:0]   elemA;
        logic [DATA_WIDTH-1:0]   elemB;
        logic [4:0]              rd;
    } pkt_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       dec_legal;
    pkt_t       dec_pkt;
    pkt_t       out_pkt;
    logic       accept;
    logic       push;
    logic       unused_instr_bits;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    // Register indices are resolved upstream; only rd travels with the packet.
    assign unused_instr_bits = ^i_instr[24:15];

    always_comb begin
        alu_op_e f3_op;
        logic    f3_ok;
        dec_legal     = 1'b0;
        dec_pkt.op    = ADD_OP;
        dec_pkt.elemA = i_rs1_data;
        dec_pkt.elemB = i_rs2_data;
        dec_pkt.rd    = i_instr[11:7];
        f3_ok         = f3_to_op(funct3, f3_op);
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE && f3_ok) begin
                    dec_legal  = 1'b1;
                    dec_pkt.op = f3_op;
                end else if (funct7 == F7_SUB && funct3 == F3_ADD_SUB) begin
                    dec_legal  = 1'b1;
                    dec_pkt.op = SUB_OP;
                end
            end
            OPC_OP_IMM: begin
                dec_pkt.elemB = DATA_WIDTH'($signed(i_instr[31:20]));
                if (f3_ok) begin
                    dec_legal  = 1'b1;
                    dec_pkt.op = f3_op;
                end
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign accept = i_valid && o_ready;
    assign push   = accept && dec_legal;

    alu_skid_buf #(
        .T (pkt_t)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (push),
        .o_ready (o_ready),
        .i_data  (dec_pkt),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (out_pkt)
    );

    assign o_op    = out_pkt.op;
    assign o_elemA = out_pkt.elemA;
    assign o_elemB = out_pkt.elemB;
    assign o_rd    = out_pkt.rd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_illegal     <= 1'b0;
            o_illegal_cnt <= '0;
        end else begin
            o_illegal <= accept && !dec_legal;
            if (accept && !dec_legal && o_illegal_cnt != '1) begin
                o_illegal_cnt <= o_illegal_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed bench for alu_issue_decoder: decode vector table plus stall, saturation
// and mid-operation reset sequences.
module tb_alu_issue_decoder;
    import alu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        o_valid;
    logic        i_ready;
    alu_op_e     o_op;
    logic [31:0] o_elemA;
    logic [31:0] o_elemB;
    logic [4:0]  o_rd;
    logic        o_illegal;
    logic [7:0]  o_illegal_cnt;

    int checks = 0;
    int errors = 0;

    alu_issue_decoder #(.DATA_WIDTH(32), .CNT_W(8)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_instr       (i_instr),
        .i_rs1_data    (i_rs1_data),
        .i_rs2_data    (i_rs2_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_op          (o_op),
        .o_elemA       (o_elemA),
        .o_elemB       (o_elemB),
        .o_rd          (o_rd),
        .o_illegal     (o_illegal),
        .o_illegal_cnt (o_illegal_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        legal;
        alu_op_e     op;
        logic [31:0] b;
        logic [4:0]  rd;
    } vec_t;

    vec_t vecs[13];

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic legal,
                                input alu_op_e op, input logic [31:0] b, input logic [4:0] rd);
        vec_t v;
        v.instr = instr; v.rs1 = rs1; v.rs2 = rs2;
        v.legal = legal; v.op = op; v.b = b; v.rd = rd;
        return v;
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        i_valid    = 1'b1;
        i_instr    = instr;
        i_rs1_data = rs1;
        i_rs2_data = rs2;
    endtask

    task automatic chk_pkt(input string name, input alu_op_e op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd);
        chk({name, ".valid"}, 32'(o_valid), 32'd1);
        chk({name, ".op"},    32'(o_op),    32'(op));
        chk({name, ".A"},     o_elemA,      a);
        chk({name, ".B"},     o_elemB,      b);
        chk({name, ".rd"},    32'(o_rd),    32'(rd));
    endtask

    int          cnt_exp;
    logic [31:0] seen_a[$];
    logic [4:0]  seen_rd[$];
    logic        pend;
    int          issued;

    initial begin
        vecs[0]  = mk(32'h002081B3, 32'd5,      32'd7,      1'b1, ADD_OP, 32'd7,        5'd3);
        vecs[1]  = mk(32'h402081B3, 32'd9,      32'd4,      1'b1, SUB_OP, 32'd4,        5'd3);
        vecs[2]  = mk(32'hFFF00093, 32'd0,      32'd99,     1'b1, ADD_OP, 32'hFFFFFFFF, 5'd1);
        vecs[3]  = mk(32'h0020C1B3, 32'd1,      32'd2,      1'b0, ADD_OP, 32'd0,        5'd0);
        vecs[4]  = mk(32'h0020F1B3, 32'h0000F0F0, 32'h00000FF0, 1'b1, AND_OP, 32'h00000FF0, 5'd3);
        vecs[5]  = mk(32'h0020E1B3, 32'd1,      32'd2,      1'b1, OR_OP,  32'd2,        5'd3);
        vecs[6]  = mk(32'h0F037293, 32'h1234,   32'hDEAD,   1'b1, AND_OP, 32'h000000F0, 5'd5);
        vecs[7]  = mk(32'h8000E393, 32'h11,     32'd0,      1'b1, OR_OP,  32'hFFFFF800, 5'd7);
        vecs[8]  = mk(32'h4020F1B3, 32'd3,      32'd3,      1'b0, ADD_OP, 32'd0,        5'd0);
        vecs[9]  = mk(32'h000010B7, 32'd3,      32'd3,      1'b0, ADD_OP, 32'd0,        5'd0);
        vecs[10] = mk(32'h022081B3, 32'd3,      32'd3,      1'b0, ADD_OP, 32'd0,        5'd0);
        vecs[11] = mk(32'h00109093, 32'd3,      32'd3,      1'b0, ADD_OP, 32'd0,        5'd0);
        vecs[12] = mk(32'h002081B3, 32'd100,    32'd200,    1'b1, ADD_OP, 32'd200,      5'd3);

        i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_instr = '0; i_rs1_data = '0; i_rs2_data = '0;
        cyc(); cyc();
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.ready", 32'(o_ready), 32'd1);
        chk("rst.op",    32'(o_op),    32'(ADD_OP));
        chk("rst.A",     o_elemA,      32'd0);
        chk("rst.B",     o_elemB,      32'd0);
        chk("rst.rd",    32'(o_rd),    32'd0);
        chk("rst.ill",   32'(o_illegal), 32'd0);
        chk("rst.cnt",   32'(o_illegal_cnt), 32'd0);
        i_rst_n = 1'b1;
        cyc();

        // Decode table, streamed back to back with the execute stage always ready.
        cnt_exp = 0;
        i_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].instr, vecs[i].rs1, vecs[i].rs2);
            cyc();
            if (!vecs[i].legal && cnt_exp < 255) cnt_exp++;
            if (vecs[i].legal) begin
                chk_pkt($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs1, vecs[i].b, vecs[i].rd);
            end else begin
                chk($sformatf("vec%0d.valid", i), 32'(o_valid), 32'd0);
            end
            chk($sformatf("vec%0d.ill", i), 32'(o_illegal), 32'(!vecs[i].legal));
            chk($sformatf("vec%0d.cnt", i), 32'(o_illegal_cnt), 32'(cnt_exp));
        end
        i_valid = 1'b0;
        cyc();
        chk("drain.valid", 32'(o_valid), 32'd0);
        chk("drain.ill",   32'(o_illegal), 32'd0);

        // Stall: three cycles with i_ready low and three packets offered.
        i_ready = 1'b0;
        drive(32'h002081B3, 32'd11, 32'd1);
        cyc();
        chk_pkt("stall0", ADD_OP, 32'd11, 32'd1, 5'd3);
        chk("stall0.ready", 32'(o_ready), 32'd1);
        drive(32'h402081B3, 32'd22, 32'd2);
        cyc();
        chk_pkt("stall1", ADD_OP, 32'd11, 32'd1, 5'd3);
        chk("stall1.ready", 32'(o_ready), 32'd0);
        drive(32'h0F037293, 32'd33, 32'd3);
        cyc();
        chk_pkt("stall2", ADD_OP, 32'd11, 32'd1, 5'd3);
        chk("stall2.ready", 32'(o_ready), 32'd0);

        i_ready = 1'b1;
        seen_a.delete();
        seen_rd.delete();
        for (int k = 0; k < 8; k++) begin
            if (o_valid) begin
                seen_a.push_back(o_elemA);
                seen_rd.push_back(o_rd);
            end
            pend = i_valid && o_ready;
            cyc();
            if (pend) i_valid = 1'b0;
        end
        chk("order.count", 32'(seen_a.size()), 32'd3);
        if (seen_a.size() == 3) begin
            chk("order.p1", seen_a[0], 32'd11);
            chk("order.p2", seen_a[1], 32'd22);
            chk("order.p3", seen_a[2], 32'd33);
            chk("order.p3rd", 32'(seen_rd[2]), 32'd5);
        end
        chk("order.empty", 32'(o_valid), 32'd0);

        // Saturate the illegal counter, then one more illegal must hold it at 255.
        for (int k = 0; k < 300 && cnt_exp < 255; k++) begin
            drive(32'h0020C1B3, 32'd0, 32'd0);
            cyc();
            cnt_exp++;
        end
        chk("sat.reach", 32'(o_illegal_cnt), 32'd255);
        drive(32'h0020C1B3, 32'd0, 32'd0);
        cyc();
        chk("sat.hold", 32'(o_illegal_cnt), 32'd255);
        chk("sat.ill",  32'(o_illegal), 32'd1);
        chk("sat.valid", 32'(o_valid), 32'd0);
        i_valid = 1'b0;
        cyc();
        chk("sat.pulse_end", 32'(o_illegal), 32'd0);

        // Fill both slots, then reset mid-operation.
        i_ready = 1'b0;
        drive(32'h002081B3, 32'd44, 32'd4);
        cyc();
        drive(32'h002081B3, 32'd55, 32'd5);
        cyc();
        i_valid = 1'b0;
        chk("full.ready", 32'(o_ready), 32'd0);
        chk("full.valid", 32'(o_valid), 32'd1);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(o_valid), 32'd0);
        chk("arst.ready", 32'(o_ready), 32'd1);
        chk("arst.cnt",   32'(o_illegal_cnt), 32'd0);
        cyc();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        issued  = 0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (o_valid) issued++;
        end
        chk("arst.no_stale", 32'(issued), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
